systolic_matrix_feeder: RTL and testbench



---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_operand_buf.sv | 53 +++++
 rtl/systolic_matrix_feeder.sv | 196 +++++++++++++++++++
 tb/tb_systolic_matrix_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array operand feeder.
package systolic_pkg;

   // Operand matrix selector on the register-write port.
   typedef enum logic {
      MAT_A = 1'b0,
      MAT_B = 1'b1
   } mat_sel_e;

   // Feeder sequencing states; the state names what the outputs show this cycle.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      STREAM    = 3'd1,
      FLUSH     = 3'd2,
      WAIT_ROWS = 3'd3,
      FINISH    = 3'd4
   } feeder_state_e;

   // Zero-data cycles needed to drain the array's input skew registers.
   function automatic int unsigned flush_cycles(input int unsigned n);
      return 2 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// Operand storage for matrices A and B with a single write port and a
// combinational column-of-A / row-of-B read. A write in the same cycle is
// forwarded to the read so a start issued with a write sees the new value.
module systolic_operand_buf
   import systolic_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned N_SIZE    = 5,
   parameter int unsigned IDX_W     = $clog2(N_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we_i,
   input  mat_sel_e             sel_i,
   input  logic [IDX_W-1:0]     row_i,
   input  logic [IDX_W-1:0]     col_i,
   input  logic [DATAWIDTH-1:0] data_i,
   input  logic [IDX_W-1:0]     rd_k_i,
   output logic [DATAWIDTH-1:0] rd_a_c_o [N_SIZE],
   output logic [DATAWIDTH-1:0] rd_b_c_o [N_SIZE]
);

   logic [DATAWIDTH-1:0] mat_a_q [N_SIZE][N_SIZE];
   logic [DATAWIDTH-1:0] mat_b_q [N_SIZE][N_SIZE];

   // Element write; indices are range-checked by the caller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N_SIZE; r++) begin
            for (int c = 0; c < N_SIZE; c++) begin
               mat_a_q[r][c] <= '0;
               mat_b_q[r][c] <= '0;
            end
         end
      end else if (we_i) begin
         if (sel_i == MAT_A) mat_a_q[row_i][col_i] <= data_i;
         else                mat_b_q[row_i][col_i] <= data_i;
      end
   end

   // Column k of A and row k of B, with write-through forwarding.
   always_comb begin
      for (int i = 0; i < N_SIZE; i++) begin
         rd_a_c_o[i] = mat_a_q[i][rd_k_i];
         rd_b_c_o[i] = mat_b_q[rd_k_i][i];
         if (we_i && (sel_i == MAT_A) && (row_i == IDX_W'(i)) && (col_i == rd_k_i))
            rd_a_c_o[i] = data_i;
         if (we_i && (sel_i == MAT_B) && (row_i == rd_k_i) && (col_i == IDX_W'(i)))
            rd_b_c_o[i] = data_i;
      end
   end

endmodule

// File: rtl/systolic_matrix_feeder.sv
// Transmit side of the systolic multiply datapath: buffers A and B, streams
// one column of A and one row of B per cycle, flushes the skew registers with
// zero data, then waits for all result rows before pulsing done.
module systolic_matrix_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned N_SIZE    = 5,
   parameter int unsigned IDX_W     = $clog2(N_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [IDX_W-1:0]     wr_row,
   input  logic [IDX_W-1:0]     wr_col,
   input  logic [DATAWIDTH-1:0] wr_data,
   output logic                 wr_err,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 start_err,
   output logic                 array_valid,
   output logic [DATAWIDTH-1:0] array_a [N_SIZE],
   output logic [DATAWIDTH-1:0] array_b [N_SIZE],
   input  logic                 array_valid_out
);

   localparam int unsigned       STEP_W     = $clog2(2 * N_SIZE);
   localparam int unsigned       ROW_W      = $clog2(N_SIZE + 1);
   localparam logic [STEP_W-1:0] LAST_COL   = STEP_W'(N_SIZE - 1);
   localparam logic [STEP_W-1:0] LAST_FLUSH = STEP_W'(flush_cycles(N_SIZE) - 1);
   localparam logic [ROW_W-1:0]  ROWS_ALL   = ROW_W'(N_SIZE);

   feeder_state_e        state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wr_err_q, wr_err_d;
   logic                 start_err_q, start_err_d;
   logic                 valid_q, valid_d;
   logic [DATAWIDTH-1:0] arr_a_q [N_SIZE];
   logic [DATAWIDTH-1:0] arr_a_d [N_SIZE];
   logic [DATAWIDTH-1:0] arr_b_q [N_SIZE];
   logic [DATAWIDTH-1:0] arr_b_d [N_SIZE];
   logic [DATAWIDTH-1:0] rd_a [N_SIZE];
   logic [DATAWIDTH-1:0] rd_b [N_SIZE];
   logic [IDX_W-1:0]     rd_k;
   logic                 wr_in_range;
   logic                 buf_we;
   logic                 rows_done;
   mat_sel_e             wr_sel_e;

   assign wr_sel_e    = mat_sel_e'(wr_sel);
   assign wr_in_range = (32'(wr_row) < N_SIZE) && (32'(wr_col) < N_SIZE);
   assign buf_we      = wr_en && (state_q == IDLE) && wr_in_range;
   // Read index is the column that will be shown next cycle.
   assign rd_k        = ((state_q == STREAM) && (step_q != LAST_COL))
                        ? IDX_W'(step_q + STEP_W'(1)) : '0;

   systolic_operand_buf #(
      .DATAWIDTH (DATAWIDTH),
      .N_SIZE    (N_SIZE),
      .IDX_W     (IDX_W)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (buf_we),
      .sel_i    (wr_sel_e),
      .row_i    (wr_row),
      .col_i    (wr_col),
      .data_i   (wr_data),
      .rd_k_i   (rd_k),
      .rd_a_c_o (rd_a),
      .rd_b_c_o (rd_b)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         row_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_err_q    <= 1'b0;
         start_err_q <= 1'b0;
         valid_q     <= 1'b0;
         for (int i = 0; i < N_SIZE; i++) begin
            arr_a_q[i] <= '0;
            arr_b_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         row_cnt_q   <= row_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wr_err_q    <= wr_err_d;
         start_err_q <= start_err_d;
         valid_q     <= valid_d;
         arr_a_q     <= arr_a_d;
         arr_b_q     <= arr_b_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      row_cnt_d   = row_cnt_q;
      done_d      = 1'b0;
      wr_err_d    = 1'b0;
      start_err_d = 1'b0;
      valid_d     = 1'b0;
      rows_done   = 1'b0;
      for (int i = 0; i < N_SIZE; i++) begin
         arr_a_d[i] = '0;
         arr_b_d[i] = '0;
      end

      // Rows may arrive as early as the flush phase, so count in all busy phases.
      if (((state_q == STREAM) || (state_q == FLUSH) || (state_q == WAIT_ROWS)) &&
          array_valid_out && (row_cnt_q != ROWS_ALL))
         row_cnt_d = row_cnt_q + ROW_W'(1);
      rows_done = (row_cnt_d == ROWS_ALL);

      // Operands are frozen and restarts refused while a run is in progress.
      if (state_q != IDLE) begin
         wr_err_d    = wr_en;
         start_err_d = start;
      end

      case (state_q)
         IDLE: begin
            wr_err_d = wr_en && !wr_in_range;
            if (start) begin
               state_d = STREAM;
               step_d  = '0;
               valid_d = 1'b1;
               arr_a_d = rd_a;
               arr_b_d = rd_b;
            end
         end
         STREAM: begin
            valid_d = 1'b1;
            if (step_q == LAST_COL) begin
               state_d = FLUSH;
               step_d  = '0;
            end else begin
               step_d  = step_q + STEP_W'(1);
               arr_a_d = rd_a;
               arr_b_d = rd_b;
            end
         end
         FLUSH: begin
            if (step_q == LAST_FLUSH) begin
               step_d = '0;
               if (rows_done) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = WAIT_ROWS;
               end
            end else begin
               step_d  = step_q + STEP_W'(1);
               valid_d = 1'b1;
            end
         end
         WAIT_ROWS: begin
            if (rows_done) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end
         end
         FINISH: begin
            state_d   = IDLE;
            step_d    = '0;
            row_cnt_d = '0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign wr_err      = wr_err_q;
   assign start_err   = start_err_q;
   assign array_valid = valid_q;
   assign array_a     = arr_a_q;
   assign array_b     = arr_b_q;

endmodule

// File: tb/tb_systolic_matrix_feeder.sv
// Directed bench for the systolic matrix feeder at N_SIZE=2 and N_SIZE=5.
module tb_systolic_matrix_feeder;

   localparam int unsigned DW = 16;

   logic clk;
   logic rst_n;

   // N_SIZE = 5 instance signals
   logic          wr_en5, wr_sel5, start5, avo5;
   logic [2:0]    wr_row5, wr_col5;
   logic [DW-1:0] wr_data5;
   logic          wr_err5, busy5, done5, start_err5, valid5;
   logic [DW-1:0] a5 [5];
   logic [DW-1:0] b5 [5];
   logic [5*DW-1:0] a5_flat, b5_flat;

   // N_SIZE = 2 instance signals
   logic          wr_en2, wr_sel2, start2, avo2;
   logic [0:0]    wr_row2, wr_col2;
   logic [DW-1:0] wr_data2;
   logic          wr_err2, busy2, done2, start_err2, valid2;
   logic [DW-1:0] a2 [2];
   logic [DW-1:0] b2 [2];
   logic [2*DW-1:0] a2_flat, b2_flat;

   int n_pass, n_fail, n_checks;
   logic [5*DW-1:0] snap_a [1:5];
   logic [5*DW-1:0] snap_b [1:5];

   systolic_matrix_feeder #(.DATAWIDTH(DW), .N_SIZE(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en5), .wr_sel(wr_sel5), .wr_row(wr_row5), .wr_col(wr_col5),
      .wr_data(wr_data5), .wr_err(wr_err5),
      .start(start5), .busy(busy5), .done(done5), .start_err(start_err5),
      .array_valid(valid5), .array_a(a5), .array_b(b5),
      .array_valid_out(avo5)
   );

   systolic_matrix_feeder #(.DATAWIDTH(DW), .N_SIZE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_row(wr_row2), .wr_col(wr_col2),
      .wr_data(wr_data2), .wr_err(wr_err2),
      .start(start2), .busy(busy2), .done(done2), .start_err(start_err2),
      .array_valid(valid2), .array_a(a2), .array_b(b2),
      .array_valid_out(avo2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flatten array outputs, element 0 in the low bits.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         a5_flat[i*DW +: DW] = a5[i];
         b5_flat[i*DW +: DW] = b5[i];
      end
      for (int i = 0; i < 2; i++) begin
         a2_flat[i*DW +: DW] = a2[i];
         b2_flat[i*DW +: DW] = b2[i];
      end
   end

   function automatic logic [DW-1:0] av(input int i, input int j);
      return DW'(32'hA000 + i * 16 + j);
   endfunction

   function automatic logic [DW-1:0] bv(input int i, input int j);
      return DW'(32'hB000 + i * 16 + j);
   endfunction

   function automatic logic [5*DW-1:0] col_a(input int k);
      logic [5*DW-1:0] r;
      for (int i = 0; i < 5; i++) r[i*DW +: DW] = av(i, k);
      return r;
   endfunction

   function automatic logic [5*DW-1:0] row_b(input int k);
      logic [5*DW-1:0] r;
      for (int j = 0; j < 5; j++) r[j*DW +: DW] = bv(k, j);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr5(input bit sel, input int r, input int c, input logic [DW-1:0] d);
      wr_en5 = 1'b1; wr_sel5 = sel; wr_row5 = 3'(r); wr_col5 = 3'(c); wr_data5 = d;
      tick();
      wr_en5 = 1'b0;
   endtask

   task automatic wr2(input bit sel, input int r, input int c, input logic [DW-1:0] d);
      wr_en2 = 1'b1; wr_sel2 = sel; wr_row2 = 1'(r); wr_col2 = 1'(c); wr_data2 = d;
      tick();
      wr_en2 = 1'b0;
   endtask

   // One N=5 run: start in cycle 0, result rows injected in cycles rs..rs+4.
   // Optional poke issues a write and a restart in cycle 1.
   task automatic run5(input int rs, input bit poke,
                       output int vcnt, output int dcnt, output int done_s,
                       output int idle_s, output int werr_s, output int serr_s);
      vcnt = 0; dcnt = 0; done_s = -1; idle_s = -1; werr_s = -1; serr_s = -1;
      start5 = 1'b1;
      for (int s = 1; s <= 30; s++) begin
         tick();
         start5 = 1'b0;
         wr_en5 = 1'b0;
         avo5   = (s >= rs) && (s < rs + 5);
         if (poke && s == 1) begin
            wr_en5 = 1'b1; wr_sel5 = 1'b0; wr_row5 = 3'd0; wr_col5 = 3'd0;
            wr_data5 = 16'd99; start5 = 1'b1;
         end
         if (s <= 5) begin
            snap_a[s] = a5_flat;
            snap_b[s] = b5_flat;
         end
         if (valid5) vcnt++;
         if (done5) begin
            dcnt++;
            if (done_s < 0) done_s = s;
         end
         if (wr_err5 && werr_s < 0) werr_s = s;
         if (start_err5 && serr_s < 0) serr_s = s;
         if (!busy5) idle_s = s;
         if (idle_s >= 0) break;
      end
      avo5 = 1'b0; wr_en5 = 1'b0; start5 = 1'b0;
   endtask

   initial begin
      int vc, dc, ds, is, we, se, seen;
      logic [5*DW-1:0] e;
      n_pass = 0; n_fail = 0; n_checks = 0;
      rst_n = 1'b0;
      wr_en5 = 0; wr_sel5 = 0; start5 = 0; avo5 = 0; wr_row5 = '0; wr_col5 = '0; wr_data5 = '0;
      wr_en2 = 0; wr_sel2 = 0; start2 = 0; avo2 = 0; wr_row2 = '0; wr_col2 = '0; wr_data2 = '0;
      tick(); tick();
      chk("rst5_ctl", {valid5, busy5, done5, wr_err5, start_err5}, 0);
      chk("rst5_a", a5_flat, 0);
      chk("rst5_b", b5_flat, 0);
      chk("rst2_ctl", {valid2, busy2, done2, wr_err2, start_err2, a2_flat, b2_flat}, 0);
      rst_n = 1'b1;
      tick();

      // N=2 sequencing, flush and done timing
      wr2(0, 0, 0, 16'd1); wr2(0, 0, 1, 16'd2); wr2(0, 1, 0, 16'd3); wr2(0, 1, 1, 16'd4);
      wr2(1, 0, 0, 16'd5); wr2(1, 0, 1, 16'd6); wr2(1, 1, 0, 16'd7); wr2(1, 1, 1, 16'd8);
      chk("n2_wr_noerr", wr_err2, 0);
      start2 = 1'b1;
      tick(); start2 = 1'b0;                          // t+1
      chk("n2_t1_valid", {valid2, busy2}, 2'b11);
      chk("n2_t1_a", a2_flat, {16'd3, 16'd1});
      chk("n2_t1_b", b2_flat, {16'd6, 16'd5});
      tick();                                         // t+2
      chk("n2_t2_a", a2_flat, {16'd4, 16'd2});
      chk("n2_t2_b", b2_flat, {16'd8, 16'd7});
      tick();                                         // t+3
      chk("n2_t3_flush", {valid2, a2_flat, b2_flat}, {1'b1, 64'd0});
      tick();                                         // t+4
      chk("n2_t4_flush", {valid2, a2_flat, b2_flat}, {1'b1, 64'd0});
      avo2 = 1'b1;
      tick();                                         // t+5
      chk("n2_t5_idle_out", {valid2, done2, busy2}, 3'b001);
      tick(); avo2 = 1'b0;                            // t+6
      chk("n2_t6_done", {done2, busy2}, 2'b11);
      tick();                                         // t+7
      chk("n2_t7_end", {done2, busy2}, 2'b00);

      // N=5 load and out-of-range writes
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            wr5(0, i, j, av(i, j));
            wr5(1, i, j, bv(i, j));
         end
      chk("n5_load_noerr", wr_err5, 0);
      wr5(0, 5, 0, 16'd7);
      chk("oor_row_err", wr_err5, 1);
      tick();
      chk("oor_err_clear", wr_err5, 0);
      wr5(1, 0, 5, 16'd7);
      chk("oor_col_err", wr_err5, 1);
      tick();

      // Run 1: rows during flush, rejected write and start while busy
      run5(6, 1'b1, vc, dc, ds, is, we, se);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("r1_a_col%0d", k), snap_a[k+1], col_a(k));
         chk($sformatf("r1_b_row%0d", k), snap_b[k+1], row_b(k));
      end
      chk("r1_valid_len", vc, 13);
      chk("r1_done_cnt", dc, 1);
      chk("r1_done_at", ds, 14);
      chk("r1_idle_at", is, 15);
      chk("r1_wr_err_at", we, 2);
      chk("r1_start_err_at", se, 2);

      // Result-row pulses while idle must not be counted
      avo5 = 1'b1;
      tick(); tick(); tick();
      avo5 = 1'b0;
      chk("idle_avo_quiet", {busy5, done5}, 2'b00);

      // Run 2: write in the start cycle, rows only after flush
      wr_en5 = 1'b1; wr_sel5 = 1'b1; wr_row5 = 3'd0; wr_col5 = 3'd2; wr_data5 = 16'h1234;
      run5(14, 1'b0, vc, dc, ds, is, we, se);
      e = row_b(0);
      e[2*DW +: DW] = 16'h1234;
      chk("r2_a_col0_kept", snap_a[1], col_a(0));
      chk("r2_b_row0_fwd", snap_b[1], e);
      chk("r2_valid_len", vc, 13);
      chk("r2_done_at", ds, 19);
      chk("r2_idle_at", is, 20);
      chk("r2_no_errs", {we, se}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});

      // Run 3: reset asserted at step k=2
      start5 = 1'b1;
      tick(); start5 = 1'b0;
      tick(); tick();
      chk("mid_col2", {valid5, a5_flat}, {1'b1, col_a(2)});
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {valid5, busy5, done5, wr_err5, start_err5}, 0);
      chk("mid_rst_data", {a5_flat, b5_flat}, 0);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (busy5 || done5 || valid5) seen++;
      end
      chk("post_rst_quiet", seen, 0);

      // Run 4: buffer was cleared; reload one element, rows start during stream
      wr5(0, 1, 0, 16'h0055);
      run5(3, 1'b0, vc, dc, ds, is, we, se);
      e = '0;
      e[1*DW +: DW] = 16'h0055;
      chk("r4_a_col0", snap_a[1], e);
      chk("r4_b_row0", snap_b[1], 0);
      chk("r4_valid_len", vc, 13);
      chk("r4_done_at", ds, 14);
      chk("r4_idle_at", is, 15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
